// File: rtl/fakepll_core.sv
// fakepll_core: behavioural PLL stand-in. An OFF/ACQ/LOCK/BYP state machine
// produces frequency and phase lock flags. Once phase lock is reached, each
// output channel runs a divider counter and emits one-cycle enable strobes.

// Per-channel divider counter and registered strobe.
module fakepll_chan #(
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          load,      // phaselock rising this edge
  input  logic          run,       // phaselock currently set
  input  logic          pl_n,      // phaselock value after this edge
  input  logic          byp_hold,  // staying in bypass across this edge
  input  logic          clken,
  input  logic [DW-1:0] divout,
  input  logic [DW-1:0] phase,
  output logic          clkout
);

  logic [DW-1:0] cnt, cnt_n;

  // Counter update: load the phase offset when lock is acquired, else wrap at divout.
  // A counter above a freshly lowered divout wraps naturally through all-ones.
  always_comb begin
    cnt_n = cnt;
    if (load)     cnt_n = (phase > divout) ? '0 : phase;
    else if (run) cnt_n = (cnt == divout) ? '0 : cnt + DW'(1);
  end

  // The strobe is registered with the counter, so it is high while the counter sits on divout.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt    <= '0;
      clkout <= 1'b0;
    end else begin
      cnt    <= cnt_n;
      clkout <= byp_hold ? clken : (pl_n & clken & (cnt_n == divout));
    end
  end

endmodule

module fakepll_core #(
  parameter int NOUT     = 8,
  parameter int DW       = 8,
  parameter int FBW      = 16,
  parameter int LOCKCYC  = 64,
  parameter int PHASECYC = 16,
  parameter int SW       = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 en,
  input  logic                 bypass,
  input  logic [FBW-1:0]       divfb,
  input  logic [NOUT-1:0]      clken,
  input  logic [NOUT*DW-1:0]   divout,
  input  logic [NOUT*DW-1:0]   phase,
  output logic [NOUT-1:0]      clkout,
  output logic                 freqlock,
  output logic                 phaselock,
  output logic [SW-1:0]        status
);

  localparam int AW = (LOCKCYC  > 1) ? $clog2(LOCKCYC)  : 1;
  localparam int PW = (PHASECYC > 1) ? $clog2(PHASECYC) : 1;

  typedef enum logic [1:0] {OFF = 2'd0, ACQ = 2'd1, LOCK = 2'd2, BYP = 2'd3} state_t;

  state_t                  state, state_n;
  logic [AW-1:0]           acq_cnt;
  logic [PW-1:0]           ph_cnt;
  logic [FBW-1:0]          divfb_q;
  logic [7:0]              relock;
  logic                    pl_n, pl_rise, byp_hold;
  logic [NOUT-1:0][DW-1:0] divout_v, phase_v;

  assign divout_v = divout;
  assign phase_v  = phase;

  // Next-state selection: enable, then bypass, then the acquire/lock progression.
  always_comb begin
    state_n = state;
    if (!en)         state_n = OFF;
    else if (bypass) state_n = BYP;
    else begin
      case (state)
        OFF, BYP: state_n = ACQ;
        ACQ:      if (acq_cnt == AW'(LOCKCYC - 1)) state_n = LOCK;
        LOCK:     if (divfb != divfb_q) state_n = ACQ;
        default:  state_n = state;
      endcase
    end
  end

  // Phase lock is sticky within one LOCK residency and drops on the edge LOCK is left.
  always_comb begin
    pl_n     = (state == LOCK) && (state_n == LOCK) &&
               (phaselock || (ph_cnt == PW'(PHASECYC - 1)));
    pl_rise  = pl_n & ~phaselock;
    byp_hold = (state == BYP) && (state_n == BYP);
  end

  // State, residency counters, feedback divider history and relock counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= OFF;
      acq_cnt   <= '0;
      ph_cnt    <= '0;
      divfb_q   <= divfb;
      relock    <= '0;
      freqlock  <= 1'b0;
      phaselock <= 1'b0;
    end else begin
      state     <= state_n;
      divfb_q   <= divfb;
      freqlock  <= (state_n == LOCK);
      phaselock <= pl_n;
      if (state_n == ACQ && state != ACQ) acq_cnt <= '0;
      else if (state == ACQ)              acq_cnt <= acq_cnt + AW'(1);
      if (state_n == LOCK && state != LOCK)                       ph_cnt <= '0;
      else if (state == LOCK && ph_cnt != PW'(PHASECYC - 1))      ph_cnt <= ph_cnt + PW'(1);
      if (state == LOCK && state_n == ACQ && relock != 8'hFF)     relock <= relock + 8'd1;
    end
  end

  // Status word: state code and relock count, everything else zero.
  always_comb begin
    status       = '0;
    status[1:0]  = state;
    status[15:8] = relock;
  end

  generate
    for (genvar i = 0; i < NOUT; i++) begin : g_ch
      fakepll_chan #(.DW(DW)) u_ch (
        .clk      (clk),
        .reset    (reset),
        .load     (pl_rise),
        .run      (phaselock),
        .pl_n     (pl_n),
        .byp_hold (byp_hold),
        .clken    (clken[i]),
        .divout   (divout_v[i]),
        .phase    (phase_v[i]),
        .clkout   (clkout[i])
      );
    end
  endgenerate

endmodule

// File: tb/tb_fakepll_core.sv
// tb_fakepll_core: directed lock/relock/bypass/reset scenarios followed by
// randomized traffic; a reference model predicts every cycle into a queue
// that a separate negedge monitor drains and compares.
module tb_fakepll_core;
  localparam int NOUT = 2, DW = 4, FBW = 16, LOCKCYC = 4, PHASECYC = 2, SW = 32;

  logic               clk = 1'b0, reset = 1'b1, en = 1'b0, bypass = 1'b0;
  logic [FBW-1:0]     divfb = '0;
  logic [NOUT-1:0]    clken = '0;
  logic [NOUT*DW-1:0] divout = '0, phase = '0;
  logic [NOUT-1:0]    clkout;
  logic               freqlock, phaselock;
  logic [SW-1:0]      status;

  always #5 clk = ~clk;

  fakepll_core #(.NOUT(NOUT), .DW(DW), .FBW(FBW), .LOCKCYC(LOCKCYC),
                 .PHASECYC(PHASECYC), .SW(SW)) dut (
    .clk(clk), .reset(reset), .en(en), .bypass(bypass), .divfb(divfb),
    .clken(clken), .divout(divout), .phase(phase), .clkout(clkout),
    .freqlock(freqlock), .phaselock(phaselock), .status(status));

  int checks = 0, passes = 0;

  task automatic chk(string name, logic [63:0] got, logic [63:0] exp);
    checks++;
    if (got === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
  endtask

  typedef struct {
    logic [NOUT-1:0] ck;
    logic            fl;
    logic            pl;
    logic [SW-1:0]   st;
  } exp_t;
  exp_t exp_q[$];

  // Reference model: mode 0 off, 1 acquiring, 2 locked, 3 bypass; residency
  // measured in cycles, channel counters as plain integers modulo 2^DW.
  int              m_st = 0, m_acq = 0, m_lk = 0, m_rel = 0;
  bit              m_pl = 0;
  logic [FBW-1:0]  m_dfb = '0;
  int              m_cnt[NOUT];
  logic [NOUT-1:0] m_ck = '0;

  task automatic model_step();
    int nm;
    bit npl;
    exp_t e;
    if (reset) begin
      m_st = 0; m_acq = 0; m_lk = 0; m_rel = 0; m_pl = 0; m_dfb = divfb; m_ck = '0;
      for (int i = 0; i < NOUT; i++) m_cnt[i] = 0;
    end else begin
      if (!en)                                        nm = 0;
      else if (bypass)                                nm = 3;
      else if (m_st == 0 || m_st == 3)                nm = 1;
      else if (m_st == 1 && m_acq == LOCKCYC - 1)     nm = 2;
      else if (m_st == 2 && divfb != m_dfb)           nm = 1;
      else                                            nm = m_st;
      npl = (m_st == 2 && nm == 2 && (m_pl || m_lk >= PHASECYC - 1));
      for (int i = 0; i < NOUT; i++) begin
        int d, p;
        d = int'(divout[i*DW +: DW]);
        p = int'(phase[i*DW +: DW]);
        if (npl && !m_pl)  m_cnt[i] = (p > d) ? 0 : p;
        else if (m_pl)     m_cnt[i] = (m_cnt[i] == d) ? 0 : (m_cnt[i] + 1) % (1 << DW);
        if (m_st == 3 && nm == 3) m_ck[i] = clken[i];
        else                      m_ck[i] = npl && clken[i] && (m_cnt[i] == d);
      end
      if (m_st == 2 && nm == 1 && m_rel < 255) m_rel++;
      m_acq = (m_st == 1 && nm == 1) ? m_acq + 1 : 0;
      m_lk  = (m_st == 2 && nm == 2) ? m_lk + 1 : 0;
      m_st  = nm;
      m_pl  = npl;
      m_dfb = divfb;
    end
    e.ck = m_ck;
    e.fl = (m_st == 2);
    e.pl = m_pl;
    e.st = '0;
    e.st[1:0]  = 2'(m_st);
    e.st[15:8] = 8'(m_rel);
    exp_q.push_back(e);
  endtask

  // One clock: let the edge happen, predict from the inputs the DUT just saw.
  task automatic tick();
    @(posedge clk);
    #1;
    model_step();
  endtask

  task automatic wait_pl();
    bit got;
    got = 0;
    for (int k = 0; k < 40 && !got; k++) begin
      tick();
      got = phaselock;
    end
    if (!got) chk("phaselock_timeout", 64'(phaselock), 64'(1));
  endtask

  // Monitor: every cycle's outputs are compared with the queued prediction.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("sb_clkout",    64'(clkout),    64'(e.ck));
        chk("sb_freqlock",  64'(freqlock),  64'(e.fl));
        chk("sb_phaselock", 64'(phaselock), 64'(e.pl));
        chk("sb_status",    64'(status),    64'(e.st));
      end
    end
  end

  initial begin
    bit found;
    int pe;
    reset = 1; en = 1; bypass = 0; divfb = 16'h1234; clken = 2'b11;
    divout = {4'd0, 4'd2}; phase = {4'd0, 4'd1};
    tick(); tick();
    chk("reset_state", 64'({clkout, freqlock, phaselock, status}), 64'(0));

    // Lock sequence and divider pattern.
    reset = 0;
    for (int e = 1; e <= 13; e++) begin
      tick();
      if (e == 1) chk("acq_edge1", 64'(status[1:0]), 64'(1));
      if (e == 4) chk("freqlock_edge4", 64'(freqlock), 64'(0));
      if (e == 5) chk("freqlock_edge5", 64'(freqlock), 64'(1));
      if (e == 6) chk("phaselock_edge6", 64'(phaselock), 64'(0));
      if (e == 7) chk("phaselock_edge7", 64'(phaselock), 64'(1));
      if (e >= 7) begin
        chk("ch0_pulse", 64'(clkout[0]), 64'(e >= 8 && (e - 8) % 3 == 0));
        chk("ch1_pulse", 64'(clkout[1]), 64'(1));
      end
    end

    // Relock on divfb change, then saturate the counter.
    divfb = divfb + 16'd1;
    tick();
    chk("relock_drop", 64'({freqlock, phaselock}), 64'(0));
    chk("relock_count1", 64'(status[15:8]), 64'(1));
    repeat (3) tick();
    chk("relock_edge3", 64'(freqlock), 64'(0));
    tick();
    chk("relock_edge4", 64'(freqlock), 64'(1));
    for (int r = 0; r < 299; r++) begin
      divfb = divfb + 16'd1;
      repeat (5) tick();
    end
    chk("relock_sat", 64'(status[15:8]), 64'(255));
    wait_pl();

    // Bypass while locked, then en=0 beats bypass.
    clken = 2'b01; bypass = 1;
    tick();
    chk("byp_state", 64'(status[1:0]), 64'(3));
    chk("byp_locks", 64'({freqlock, phaselock}), 64'(0));
    tick();
    chk("byp_clkout", 64'(clkout), 64'(2'b01));
    en = 0;
    tick();
    chk("off_prio_state", 64'(status[1:0]), 64'(0));
    chk("off_prio_clkout", 64'(clkout), 64'(0));

    // Masking keeps the pulse phase.
    en = 1; bypass = 0; clken = 2'b11;
    wait_pl();
    found = 0;
    for (int k = 0; k < 10 && !found; k++) begin
      tick();
      found = clkout[0];
    end
    if (!found) chk("ch0_pulse_timeout", 64'(clkout[0]), 64'(1));
    clken = 2'b00;
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("masked", 64'(clkout), 64'(0));
    end
    clken = 2'b11;
    tick();
    chk("phase_kept_hi", 64'(clkout[0]), 64'(1));
    tick();
    chk("phase_kept_lo", 64'(clkout[0]), 64'(0));

    // Reset mid-LOCK, then phase offset beyond divout loads zero.
    reset = 1;
    tick();
    chk("reset_midlock", 64'({clkout, freqlock, phaselock, status}), 64'(0));
    divout = {4'd0, 4'd3}; phase = {4'd0, 4'd5};
    reset = 0;
    wait_pl();
    pe = 0;
    for (int k = 0; k < 4; k++) begin
      if (k > 0) tick();
      chk("clamp_load", 64'(clkout[0]), 64'(k == 3));
      pe++;
    end

    // Randomized traffic.
    for (int c = 0; c < 600; c++) begin
      reset = ($urandom_range(0, 99) == 0);
      if (en) en = ($urandom_range(0, 39) != 0);
      else    en = ($urandom_range(0, 3) == 0);
      if (bypass) bypass = ($urandom_range(0, 3) != 0);
      else        bypass = ($urandom_range(0, 49) == 0);
      if ($urandom_range(0, 11) == 0) divfb = 16'($urandom);
      if ($urandom_range(0, 7) == 0)  clken = NOUT'($urandom);
      if ($urandom_range(0, 24) == 0) divout = (NOUT*DW)'($urandom);
      if ($urandom_range(0, 24) == 0) phase  = (NOUT*DW)'($urandom);
      tick();
    end

    repeat (3) @(negedge clk);
    chk("queue_drained", 64'(exp_q.size()), 64'(0));
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
